// File: rtl/mc_sequencer_if.sv
// Memory handshake bundle between the control sequencer and the instruction/data memories.
// The sequencer drives requests and the store strobe; memories answer with ready.
interface mc_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic dmem_req;
    logic dmem_ready;
    logic dmem_wren;

    modport master (
        output imem_req,
        output dmem_req,
        output dmem_wren,
        input  imem_ready,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        input  dmem_wren,
        output imem_ready,
        output dmem_ready
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle RV32I control sequencer: 3-5 cycles per instruction plus memory waits.
// Stalls in FETCH/MEMORY until ready, halting with a timeout cause after MEM_TIMEOUT waits.
module mc_sequencer #(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    mc_sequencer_if.master       mem,
    input  logic [6:0]           opcode,
    input  logic                 branch_cond,
    input  logic                 resume,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           writeback_mux,
    output logic [2:0]           state,
    output logic                 halted,
    output logic [1:0]           halt_cause,
    output logic [CNT_WIDTH-1:0] cycle_cnt,
    output logic [CNT_WIDTH-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_SYSTEM  = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    // Wait counter only ever holds values below MEM_TIMEOUT.
    localparam int              WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W:0] TIMEOUT_V = (WAIT_W + 1)'(MEM_TIMEOUT);

    state_t            cur_state;
    state_t            nxt_state;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_d;
    logic              timeout_hit;

    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_system;
    logic is_legal;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign is_system = (opcode == OP_SYSTEM);

    always_comb begin
        case (opcode)
            OP_R, OP_IALU, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: is_legal = 1'b1;
            default:                                      is_legal = 1'b0;
        endcase
    end

    // Fires on the wait cycle that would bring the counter up to MEM_TIMEOUT.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (({1'b0, wait_q} + 1'b1) == TIMEOUT_V);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
            cause_q   <= CAUSE_NONE;
            wait_q    <= '0;
        end else begin
            cur_state <= nxt_state;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
        end
    end

    always_comb begin
        nxt_state = cur_state;
        cause_d   = cause_q;
        wait_d    = wait_q;
        case (cur_state)
            S_FETCH: begin
                if (mem.imem_ready) begin
                    nxt_state = S_DECODE;
                    wait_d    = '0;
                end else if (timeout_hit) begin
                    nxt_state = S_HALT;
                    cause_d   = CAUSE_TIMEOUT;
                    wait_d    = '0;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_DECODE: begin
                if (!is_legal) begin
                    nxt_state = S_HALT;
                    cause_d   = CAUSE_ILLEGAL;
                end else if (is_system) begin
                    nxt_state = S_HALT;
                    cause_d   = CAUSE_SYSTEM;
                end else begin
                    nxt_state = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    nxt_state = S_FETCH;
                end else if (is_load || is_store) begin
                    nxt_state = S_MEMORY;
                end else begin
                    nxt_state = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem.dmem_ready) begin
                    nxt_state = is_load ? S_WRITEBACK : S_FETCH;
                    wait_d    = '0;
                end else if (timeout_hit) begin
                    nxt_state = S_HALT;
                    cause_d   = CAUSE_TIMEOUT;
                    wait_d    = '0;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                nxt_state = S_FETCH;
            end
            S_HALT: begin
                // Only an ECALL/EBREAK halt is resumable; the others need reset.
                if ((cause_q == CAUSE_SYSTEM) && resume) begin
                    nxt_state = S_FETCH;
                    cause_d   = CAUSE_NONE;
                end
            end
            default: begin
                nxt_state = S_FETCH;
                cause_d   = CAUSE_NONE;
                wait_d    = '0;
            end
        endcase
    end

    always_comb begin
        mem.imem_req  = 1'b0;
        mem.dmem_req  = 1'b0;
        mem.dmem_wren = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        writeback_mux = 2'b00;
        if (!reset) begin
            case (cur_state)
                S_FETCH: begin
                    mem.imem_req = 1'b1;
                    ir_write     = mem.imem_ready;
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_R, OP_BRANCH: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b00;
                        end
                        OP_IALU, OP_LOAD, OP_STORE, OP_JALR: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 2'b10;
                        end
                        OP_JAL, OP_AUIPC: begin
                            alu_src_a = 2'b00;
                            alu_src_b = 2'b10;
                        end
                        OP_LUI: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 2'b10;
                        end
                        default: begin
                            alu_src_a = 2'b00;
                            alu_src_b = 2'b00;
                        end
                    endcase
                    if (is_branch) begin
                        pc_write = 1'b1;
                        pc_src   = branch_cond;
                    end
                end
                S_MEMORY: begin
                    mem.dmem_req  = 1'b1;
                    mem.dmem_wren = is_store;
                    pc_write      = is_store && mem.dmem_ready;
                end
                S_WRITEBACK: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = is_jump;
                    if (is_load) begin
                        writeback_mux = 2'b01;
                    end else if (opcode == OP_LUI) begin
                        writeback_mux = 2'b10;
                    end else if (is_jump) begin
                        writeback_mux = 2'b11;
                    end
                end
                S_HALT: begin
                    pc_write = (cause_q == CAUSE_SYSTEM) && resume;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            instret   <= '0;
        end else begin
            if (cur_state != S_HALT) begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
            if (pc_write) begin
                instret <= instret + 1'b1;
            end
        end
    end

    assign state      = cur_state;
    assign halted     = (cur_state == S_HALT);
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Randomized instruction-stream bench for mc_sequencer against a per-phase reference model.
module tb_mc_sequencer;
    localparam logic [6:0] R_OP  = 7'b0110011, I_OP  = 7'b0010011, LD_OP = 7'b0000011;
    localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, JAL_OP = 7'b1101111;
    localparam logic [6:0] JALR_OP = 7'b1100111, LUI_OP = 7'b0110111, AUIPC_OP = 7'b0010111;
    localparam logic [6:0] SYS_OP = 7'b1110011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [6:0] opcode;
    logic       branch_cond;
    logic       resume;

    mc_sequencer_if mif ();
    mc_sequencer_if mif0 ();

    logic        ir_write, pc_write, pc_src, reg_write, halted;
    logic [1:0]  alu_src_a, alu_src_b, writeback_mux, halt_cause;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret;

    logic        ir_write0, pc_write0, pc_src0, reg_write0, halted0;
    logic [1:0]  alu_src_a0, alu_src_b0, writeback_mux0, halt_cause0;
    logic [2:0]  state0;
    logic [31:0] cycle_cnt0, instret0;

    mc_sequencer #(.CNT_WIDTH(32), .MEM_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .mem(mif), .opcode(opcode), .branch_cond(branch_cond),
        .resume(resume), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .writeback_mux(writeback_mux), .state(state), .halted(halted),
        .halt_cause(halt_cause), .cycle_cnt(cycle_cnt), .instret(instret)
    );

    mc_sequencer #(.CNT_WIDTH(32), .MEM_TIMEOUT(0)) dut0 (
        .clk(clk), .reset(reset), .mem(mif0), .opcode(opcode), .branch_cond(branch_cond),
        .resume(resume), .ir_write(ir_write0), .pc_write(pc_write0), .pc_src(pc_src0),
        .reg_write(reg_write0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
        .writeback_mux(writeback_mux0), .state(state0), .halted(halted0),
        .halt_cause(halt_cause0), .cycle_cnt(cycle_cnt0), .instret(instret0)
    );

    // Second instance never sees imem_ready, so it should just count cycles forever.
    int n0;
    always @(posedge clk or posedge reset) begin
        if (reset) n0 <= 0;
        else       n0 <= n0 + 1;
    end

    logic [12:0] obs;
    assign obs = {mif.imem_req, mif.dmem_req, mif.dmem_wren, ir_write, pc_write, pc_src,
                  reg_write, alu_src_a, alu_src_b, writeback_mux};

    int      total = 0;
    int      bad   = 0;
    longint  m_cycle;
    longint  m_instret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic logic [12:0] pk(input logic ireq, input logic dreq, input logic wr,
                                       input logic ir, input logic pw, input logic ps,
                                       input logic rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] wb);
        return {ireq, dreq, wr, ir, pw, ps, rw, a, b, wb};
    endfunction

    // Operand selects the ALU needs for each instruction class.
    function automatic logic [3:0] alu_sel(input logic [6:0] op);
        if (op == R_OP || op == BR_OP)      return 4'b01_00;
        if (op == JAL_OP || op == AUIPC_OP) return 4'b00_10;
        if (op == LUI_OP)                   return 4'b10_10;
        return 4'b01_10;
    endfunction

    function automatic logic [1:0] wb_sel(input logic [6:0] op);
        if (op == LD_OP)                    return 2'b01;
        if (op == LUI_OP)                   return 2'b10;
        if (op == JAL_OP || op == JALR_OP)  return 2'b11;
        return 2'b00;
    endfunction

    // One clock: apply inputs, check mid-cycle, advance the model on the edge.
    task automatic do_cycle(input string tag, input logic [2:0] exp_st, input logic [12:0] exp_strb,
                            input logic imr, input logic dmr, input logic res);
        mif.imem_ready  = imr;
        mif.dmem_ready  = dmr;
        resume          = res;
        @(negedge clk);
        check({tag, "/state"},  state, exp_st);
        check({tag, "/halted"}, halted, exp_st == 3'd5);
        check({tag, "/strobe"}, obs, exp_strb);
        @(posedge clk);
        #1;
        if (exp_st != 3'd5) m_cycle++;
        if (exp_strb[8])    m_instret++;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "/instret"}, instret, m_instret[31:0]);
        check({tag, "/cycles"},  cycle_cnt, m_cycle[31:0]);
    endtask

    task automatic fetch_decode(input logic [6:0] op, input int iw);
        for (int k = 0; k <= iw; k++) begin
            opcode = 7'($urandom);
            do_cycle("fetch", 3'd0, pk(1, 0, 0, k == iw, 0, 0, 0, 0, 0, 0), k == iw, 0, 0);
        end
        opcode = op;
        do_cycle("decode", 3'd1, 13'd0, 0, 0, 0);
    endtask

    task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic bc);
        logic ld, st, br, jmp;
        logic [3:0] ab;
        ld  = (op == LD_OP);
        st  = (op == ST_OP);
        br  = (op == BR_OP);
        jmp = (op == JAL_OP) || (op == JALR_OP);
        ab  = alu_sel(op);
        branch_cond = bc;
        fetch_decode(op, iw);
        do_cycle("exec", 3'd2, pk(0, 0, 0, 0, br, br & bc, 0, ab[3:2], ab[1:0], 0), 0, 0, 0);
        if (ld || st) begin
            for (int k = 0; k <= dw; k++)
                do_cycle("mem", 3'd3, pk(0, 1, st, 0, st && k == dw, 0, 0, 0, 0, 0), 0, k == dw, 0);
        end
        if (!br && !st)
            do_cycle("wb", 3'd4, pk(0, 0, 0, 0, 1, jmp, 1, 0, 0, wb_sel(op)), 0, 0, 0);
        check_counters("retire");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        resume = 1'b0;
        @(posedge clk);
        #1;
        check("rst/state", state, 3'd0);
        check("rst/strobe", obs, 13'd0);
        check("rst/cause", halt_cause, 2'd0);
        check("rst/cycles", cycle_cnt, 32'd0);
        check("rst/instret", instret, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cycle = 0;
        m_instret = 0;
    endtask

    logic [6:0] ops [9] = '{R_OP, I_OP, LD_OP, ST_OP, BR_OP, JAL_OP, JALR_OP, LUI_OP, AUIPC_OP};

    initial begin
        logic [6:0] bad_op;
        reset = 1'b0;
        opcode = I_OP;
        branch_cond = 1'b0;
        resume = 1'b0;
        mif.imem_ready = 1'b0;
        mif.dmem_ready = 1'b0;
        mif0.imem_ready = 1'b0;
        mif0.dmem_ready = 1'b0;
        #2;
        do_reset();

        // Directed cases from the bring-up plan, then boundary waits.
        run_instr(I_OP, 0, 0, 0);
        run_instr(LD_OP, 0, 3, 0);
        run_instr(BR_OP, 0, 0, 1);
        run_instr(BR_OP, 0, 0, 0);
        run_instr(JAL_OP, 0, 0, 0);
        run_instr(ST_OP, 2, 1, 0);
        run_instr(I_OP, 15, 0, 0);
        run_instr(LD_OP, 0, 15, 0);
        run_instr(ST_OP, 15, 15, 0);

        for (int n = 0; n < 150; n++) begin
            run_instr(ops[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3),
                      1'($urandom));
        end

        // EBREAK/ECALL: halt, counters freeze, resume retires it.
        fetch_decode(SYS_OP, $urandom_range(0, 2));
        check("sys/cause", halt_cause, 2'd1);
        for (int k = 0; k < 5; k++) do_cycle("sys/halt", 3'd5, 13'd0, 1'($urandom), 1'($urandom), 0);
        check_counters("sys/frozen");
        do_cycle("sys/resume", 3'd5, pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 0, 0, 1);
        check("sys/state_after", state, 3'd0);
        check("sys/cause_after", halt_cause, 2'd0);
        check_counters("sys/resumed");
        run_instr(R_OP, 1, 0, 0);

        // Illegal opcodes halt for good.
        for (int t = 0; t < 2; t++) begin
            bad_op = 7'd0;
            if (t == 1) begin
                do bad_op = 7'($urandom); while (bad_op inside {ops, SYS_OP});
            end
            fetch_decode(bad_op, 0);
            check("ill/cause", halt_cause, 2'd2);
            for (int k = 0; k < 4; k++) do_cycle("ill/halt", 3'd5, 13'd0, 0, 0, 1);
            check_counters("ill/frozen");
            do_reset();
        end

        // Fetch timeout after 16 unanswered cycles; resume must not leave HALT.
        for (int k = 0; k < 16; k++) do_cycle("to/fetch", 3'd0, pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        check("to/cause", halt_cause, 2'd3);
        for (int k = 0; k < 20; k++) do_cycle("to/halt", 3'd5, 13'd0, 0, 0, 1);
        check_counters("to/frozen");
        check("nto/halted", halted0, 1'b0);
        check("nto/state", state0, 3'd0);
        check("nto/cycles", cycle_cnt0, 32'(n0));
        do_reset();

        // Reset while waiting in MEMORY aborts the load with nothing retired.
        run_instr(I_OP, 0, 0, 0);
        fetch_decode(LD_OP, 0);
        do_cycle("ab/exec", 3'd2, pk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b10, 0), 0, 0, 0);
        do_cycle("ab/mem", 3'd3, pk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("ab/state", state, 3'd0);
        check("ab/dmem_req", mif.dmem_req, 1'b0);
        check("ab/cycles", cycle_cnt, 32'd0);
        check("ab/instret", instret, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cycle = 0;
        m_instret = 0;
        run_instr(I_OP, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Parametrised multi-cycle control sequencer for the RV32I core. It replaces the fixed-timing control unit.
- Drives every datapath strobe and mux select, and handshakes with variable-latency instruction and data memory through req/ready.
- Halts on ECALL/EBREAK, on an illegal opcode, or on a memory timeout, and reports the halt cause.
- Maintains cycle and retired-instruction counters. Sits between the instruction decoder and the datapath muxes in top.

Parameters:
- CNT_WIDTH, 32, width of the cycle and instret counters.
- MEM_TIMEOUT, 16, maximum wait cycles for imem_ready/dmem_ready before a timeout halt; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  from the decoder; stable from DECODE until the instruction retires
- branch_cond  in  1  ALU comparison result; 1 = branch taken
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access completes this cycle
- resume  in  1  leave HALT after ECALL/EBREAK
- imem_req  out  1  fetch request
- dmem_req  out  1  data access request
- dmem_wren  out  1  store strobe
- ir_write  out  1  latch the instruction register
- pc_write  out  1  update the PC (retire)
- pc_src  out  1  0 = PC+4, 1 = ALU target
- reg_write  out  1  register file write enable
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = zero
- alu_src_b  out  2  00 = rs2, 01 = 4, 10 = imm
- writeback_mux  out  2  00 = ALU, 01 = mem, 10 = imm, 11 = PC+4
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5
- halted  out  1  state==HALT
- halt_cause  out  2  00 none, 01 ECALL/EBREAK, 10 illegal opcode, 11 timeout
- cycle_cnt  out  CNT_WIDTH  cycles spent outside HALT
- instret  out  CNT_WIDTH  retired instructions

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous, active-high.
- Reset values: state=FETCH, halt_cause=00, counters=0, wait counter=0.
- While reset is high, every strobe and request is 0. Selects default to 00 when not specified below.
- Registered vs combinational: state, halt_cause, counters and the wait counter are registered. Strobes and selects are combinational from state, opcode and the ready inputs (Mealy on the ready inputs).

FETCH:
- imem_req=1.
- On imem_ready: ir_write=1, go to DECODE, clear the wait counter.
- Otherwise increment the wait counter. When MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT, go to HALT with cause 11.

DECODE:
- Illegal opcode → HALT, cause 10.
- 1110011 → HALT, cause 01.
- Any other opcode → EXECUTE.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.

EXECUTE (ALU operands per opcode):
- R-type: a=01, b=00.
- I-ALU, load, store, JALR: a=01, b=10.
- JAL, AUIPC: a=00, b=10.
- LUI: a=10, b=10.
- Branch: a=01, b=00. Asserts pc_write=1 with pc_src=branch_cond, retires, then goes to FETCH.
- Load and store go to MEMORY; all other opcodes go to WRITEBACK.

MEMORY:
- dmem_req=1 every cycle; dmem_wren=1 for stores.
- Waits for dmem_ready, with the same timeout rule as FETCH.
- Load on ready → WRITEBACK.
- Store on ready → pc_write=1, pc_src=0, retire, go to FETCH.

WRITEBACK:
- reg_write=1 and pc_write=1, then go to FETCH.
- writeback_mux: load 01, LUI 10, JAL/JALR 11, otherwise 00.
- pc_src=1 for JAL/JALR, else 0.

HALT:
- All strobes 0 and the counters freeze.
- For cause 01 only, resume=1 issues pc_write=1, pc_src=0, retires the ECALL/EBREAK, clears the cause and goes to FETCH.
- For causes 10 and 11, resume is ignored; only reset exits HALT.

Counters:
- instret increments in every cycle with pc_write=1.
- cycle_cnt increments in every cycle with state!=HALT.
- Both wrap modulo 2^CNT_WIDTH.

Latencies with zero-wait memory:
- ALU, LUI, AUIPC, JAL, JALR: 4 cycles.
- Branch: 3 cycles.
- Store: 4 cycles.
- Load: 5 cycles.
- Each wait cycle adds 1.

Edge cases:
- A ready input arriving in the same cycle the wait counter hits MEM_TIMEOUT counts as success; ready wins.
- Reset mid-instruction aborts it, with no partial retire.

Test Plan:
- ADDI 0010011 with imem_ready/dmem_ready tied 1 → states 0,1,2,4. WRITEBACK shows reg_write=1, pc_write=1, writeback_mux=00. instret=1 and cycle_cnt=4 after the instruction.
- LW with dmem_ready delayed 3 cycles → MEMORY lasts 4 cycles with dmem_req=1 and dmem_wren=0. Then WRITEBACK with writeback_mux=01; total 8 cycles.
- BEQ with branch_cond=1, then again with branch_cond=0 → EXECUTE asserts pc_write with pc_src=1, then pc_src=0. Each instruction takes 3 cycles, with no reg_write.
- JAL → EXECUTE a=00, b=10. WRITEBACK has writeback_mux=11, pc_src=1, reg_write=1.
- imem_ready held 0 with MEM_TIMEOUT=16 → HALT after 16 FETCH cycles with halt_cause=11, and resume has no effect. Also set MEM_TIMEOUT=0 → never halts.
- EBREAK → HALT with cause 01 and frozen counters. resume=1 → pc_write=1, instret+1, FETCH. Opcode 0000000 → HALT with cause 10. Async reset asserted in MEMORY → immediate state=0, counters 0, dmem_req=0.
